spi_upcount_tx_sched: RTL and testbench
=======================================

Name: spi_upcount_tx_sched

Overview:
Transmit scheduler between the upcounter control/datapath and the byte-wide SPI master. On each tick, or on a forced request, it takes a snapshot of the 14-bit counter and the run/stop status. It frames the snapshot as two SPI bytes inside one SS-low window, sequencing start/done handshakes, SS setup/hold and the inter-byte gap. It also tracks overruns, done-timeouts and the number of completed frames.

Parameters:
CNT_W, 14, counter width; must be ≤ 14 so it fits in {byte0[5:0], byte1}
SS_SETUP, 2, cycles SS is low before the first start pulse (≥1)
BYTE_GAP, 4, idle cycles between done of byte0 and start of byte1 (≥1)
SS_HOLD, 2, cycles SS stays low after done of byte1 (≥1)
TIMEOUT_CYCLES, 4096, max cycles in a WAIT state before abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_tick  in  1  1-cycle frame request from the tick generator
i_force  in  1  1-cycle frame request from the CU (e.g. after CLEAR)
i_counter  in  CNT_W  live counter value
i_runstop  in  1  CU run status (1 = RUN)
i_err_clr  in  1  clears the sticky error flags
o_start  out  1  1-cycle start pulse to the SPI master
o_tx_data  out  8  byte presented to the SPI master
i_done  in  1  1-cycle byte-complete pulse from the SPI master
o_ss  out  1  slave select, active-low
o_busy  out  1  high whenever state != IDLE
o_overrun  out  1  sticky: a request arrived while one was already pending
o_timeout  out  1  sticky: i_done missing for TIMEOUT_CYCLES
o_frame_cnt  out  16  completed frames; wraps 0xFFFF→0

Behaviour:
- Reset values: o_start=0, o_tx_data=0, o_ss=1, o_busy=0, o_overrun=0, o_timeout=0, o_frame_cnt=0. Internal state: pending=0, state=IDLE, timer=0.
- Request: req = i_tick | i_force. Two requests in the same cycle count as one.
- Frame format, snapshot taken on the IDLE exit cycle:
  - byte0 = {i_runstop, 1'b0, i_counter[13:8]}
  - byte1 = i_counter[7:0]
  - Unused high bits are zero-extended when CNT_W < 14.
- States:
  - IDLE: on (req | pending), snapshot, clear pending, o_ss←0, go SETUP.
  - SETUP: hold SS_SETUP cycles, then o_start=1 for one cycle with o_tx_data=byte0, go WAIT0.
  - WAIT0: on i_done, go GAP.
  - GAP: hold BYTE_GAP cycles, then o_start=1 with o_tx_data=byte1, go WAIT1.
  - WAIT1: on i_done, go HOLD.
  - HOLD: hold SS_HOLD cycles, then o_ss←1, o_frame_cnt+1, go IDLE.
- Latency:
  - First o_start is SS_SETUP+1 cycles after the request cycle.
  - IDLE lasts at least 1 cycle with o_ss=1 between frames.
- o_tx_data is held stable from the o_start cycle through i_done. i_done outside WAIT0/WAIT1 is ignored.
- req while not IDLE:
  - if pending=0, set pending;
  - if pending=1, set o_overrun.
  - Depth is one. A pending frame sends the value snapshotted when it starts, not the value at the time of the request.
- req on the HOLD→IDLE transition cycle sets pending; the next frame starts in the following IDLE cycle.
- Timeout:
  - The timer restarts on entry to WAIT0/WAIT1.
  - After TIMEOUT_CYCLES cycles with no i_done: set o_timeout, o_ss←1, no frame_cnt increment, go IDLE. pending is kept.
- Sticky flags: i_err_clr clears both flags. A set and a clear in the same cycle: set wins.
- Reset asserted mid-frame returns all outputs to their reset values immediately (asynchronously); SS releases at once.

Decomposition:
- Package spi_upcount_pkg holds:
  - sched_state_t enum (IDLE, SETUP, WAIT0, GAP, WAIT1, HOLD);
  - FRAME_RUN_BIT=7, FRAME_RSVD_BIT=6;
  - default timing constants.
- One sub-module, spi_wait_timer: a loadable down-counter with a zero flag, reused for setup, gap, hold and timeout. The frame packer stays inline.

Test Plan:
1. Counter=0x1ABC, runstop=1, pulse i_tick; SPI model returns done 20 cycles after each start → bytes 0x9A then 0xBC. o_ss low for the whole frame; first o_start 3 cycles after the tick; byte1 start 4 cycles after done0; o_frame_cnt=1.
2. runstop=0, counter=0, pulse i_force → bytes 0x00, 0x00; o_busy high throughout, low after HOLD+1.
3. Tick during WAIT0, then a second tick during GAP → the pending frame follows after exactly one IDLE cycle with o_ss=1; o_overrun=1; o_frame_cnt=2 at the end. Pulse i_err_clr → o_overrun=0.
4. SPI model never returns done, TIMEOUT_CYCLES=16 → o_timeout=1 after 16 WAIT0 cycles, o_ss=1, o_frame_cnt unchanged. A later done pulse is ignored. The next tick sends a normal frame.
5. Assert reset in GAP → o_ss=1, o_start=0, o_frame_cnt=0 and state IDLE without waiting for a clock edge. Deassert, then tick → clean frame.
6. Force o_frame_cnt to 0xFFFF via 65535 quick frames, or preload in a short-parameter sim, then one more frame → o_frame_cnt=0.

Source files
------------

// File: rtl/spi_upcount_pkg.sv
// Shared types and constants for the upcounter SPI transmit scheduler.
package spi_upcount_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WAIT0 = 3'd2,
    GAP   = 3'd3,
    WAIT1 = 3'd4,
    HOLD  = 3'd5
  } sched_state_t;

  localparam int FRAME_RUN_BIT  = 7;
  localparam int FRAME_RSVD_BIT = 6;

  localparam int DEF_CNT_W          = 14;
  localparam int DEF_SS_SETUP       = 2;
  localparam int DEF_BYTE_GAP       = 4;
  localparam int DEF_SS_HOLD        = 2;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // {byte0, byte1}: byte0 carries run status, a reserved zero and counter[13:8].
  function automatic logic [15:0] pack_frame(input logic run, input logic [13:0] cnt);
    logic [7:0] b0;
    b0                 = '0;
    b0[FRAME_RUN_BIT]  = run;
    b0[FRAME_RSVD_BIT] = 1'b0;
    b0[5:0]            = cnt[13:8];
    return {b0, cnt[7:0]};
  endfunction

endpackage

// File: rtl/spi_upcount_tx_sched_timer.sv
// Loadable down-counter with a zero flag; shared by setup, gap, hold and timeout.
module spi_wait_timer
  import spi_upcount_pkg::*;
#(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/spi_upcount_tx_sched.sv
// Frames a counter/run snapshot as two SPI bytes within one SS-low window,
// with overrun/timeout flags and a completed-frame counter.
module spi_upcount_tx_sched
  import spi_upcount_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int SS_SETUP       = DEF_SS_SETUP,
  parameter int BYTE_GAP       = DEF_BYTE_GAP,
  parameter int SS_HOLD        = DEF_SS_HOLD,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_force,
  input  logic [CNT_W-1:0] i_counter,
  input  logic             i_runstop,
  input  logic             i_err_clr,
  output logic             o_start,
  output logic [7:0]       o_tx_data,
  input  logic             i_done,
  output logic             o_ss,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_timeout,
  output logic [15:0]      o_frame_cnt
);

  localparam int TMAX = max_int(max_int(SS_SETUP, BYTE_GAP), max_int(SS_HOLD, TIMEOUT_CYCLES));
  localparam int TW   = $clog2(TMAX + 1);

  sched_state_t  r_state;
  logic          r_pending, r_start, r_ss, r_overrun, r_timeout;
  logic [7:0]    r_tx_data, r_byte0, r_byte1;
  logic [15:0]   r_frame_cnt;

  logic          w_req, w_tzero, w_load, w_ovr_set, w_to_set, w_in_wait;
  logic [TW-1:0] w_load_val;
  logic [15:0]   w_frame;

  assign w_req     = i_tick | i_force;
  assign w_frame   = pack_frame(i_runstop, 14'(i_counter));
  assign w_in_wait = (r_state == WAIT0) || (r_state == WAIT1);
  assign w_to_set  = w_in_wait && !i_done && w_tzero;
  assign w_ovr_set = w_req && (r_state != IDLE) && r_pending;

  // The done cycle counts as the first gap cycle, so the gap timer is loaded
  // one short; a one-cycle gap skips the GAP state entirely.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      IDLE: if (w_req || r_pending) begin
        w_load     = 1'b1;
        w_load_val = TW'(SS_SETUP - 1);
      end
      SETUP, GAP: if (w_tzero) begin
        w_load     = 1'b1;
        w_load_val = TW'(TIMEOUT_CYCLES - 1);
      end
      WAIT0: if (i_done) begin
        w_load     = 1'b1;
        w_load_val = (BYTE_GAP > 1) ? TW'(BYTE_GAP - 2) : TW'(TIMEOUT_CYCLES - 1);
      end
      WAIT1: if (i_done) begin
        w_load     = 1'b1;
        w_load_val = TW'(SS_HOLD - 1);
      end
      default: ;
    endcase
  end

  spi_wait_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_tzero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pending   <= 1'b0;
      r_start     <= 1'b0;
      r_tx_data   <= '0;
      r_ss        <= 1'b1;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
      r_frame_cnt <= '0;
      r_byte0     <= '0;
      r_byte1     <= '0;
    end else begin
      r_start <= 1'b0;

      if (w_ovr_set)      r_overrun <= 1'b1;
      else if (i_err_clr) r_overrun <= 1'b0;
      if (w_to_set)       r_timeout <= 1'b1;
      else if (i_err_clr) r_timeout <= 1'b0;

      if (w_req && (r_state != IDLE) && !r_pending) r_pending <= 1'b1;

      case (r_state)
        IDLE: if (w_req || r_pending) begin
          r_byte0   <= w_frame[15:8];
          r_byte1   <= w_frame[7:0];
          r_pending <= 1'b0;
          r_ss      <= 1'b0;
          r_state   <= SETUP;
        end
        SETUP: if (w_tzero) begin
          r_start   <= 1'b1;
          r_tx_data <= r_byte0;
          r_state   <= WAIT0;
        end
        WAIT0: begin
          if (i_done) begin
            if (BYTE_GAP > 1) begin
              r_state <= GAP;
            end else begin
              r_start   <= 1'b1;
              r_tx_data <= r_byte1;
              r_state   <= WAIT1;
            end
          end else if (w_tzero) begin
            r_ss    <= 1'b1;
            r_state <= IDLE;
          end
        end
        GAP: if (w_tzero) begin
          r_start   <= 1'b1;
          r_tx_data <= r_byte1;
          r_state   <= WAIT1;
        end
        WAIT1: begin
          if (i_done) begin
            r_state <= HOLD;
          end else if (w_tzero) begin
            r_ss    <= 1'b1;
            r_state <= IDLE;
          end
        end
        HOLD: if (w_tzero) begin
          r_ss        <= 1'b1;
          r_frame_cnt <= r_frame_cnt + 16'd1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_start     = r_start;
  assign o_tx_data   = r_tx_data;
  assign o_ss        = r_ss;
  assign o_busy      = (r_state != IDLE);
  assign o_overrun   = r_overrun;
  assign o_timeout   = r_timeout;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_spi_upcount_tx_sched.sv
// Directed bench for spi_upcount_tx_sched: framing, latency, pending/overrun,
// timeout, async reset and frame-counter wrap.
module tb_spi_upcount_tx_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] counter = '0;
  logic        runstop = 1'b0;
  logic        err_clr = 1'b0;

  logic        a_tick = 1'b0, a_force = 1'b0, a_done = 1'b0;
  logic        a_start, a_ss, a_busy, a_ovr, a_to;
  logic [7:0]  a_tx;
  logic [15:0] a_fc;

  logic        b_tick = 1'b0, b_force = 1'b0, b_done = 1'b0;
  logic        b_start, b_ss, b_busy, b_ovr, b_to;
  logic [7:0]  b_tx;
  logic [15:0] b_fc;

  always #5 clk = ~clk;

  spi_upcount_tx_sched dut_a (
    .clk(clk), .reset(reset), .i_tick(a_tick), .i_force(a_force),
    .i_counter(counter), .i_runstop(runstop), .i_err_clr(err_clr),
    .o_start(a_start), .o_tx_data(a_tx), .i_done(a_done), .o_ss(a_ss),
    .o_busy(a_busy), .o_overrun(a_ovr), .o_timeout(a_to), .o_frame_cnt(a_fc)
  );

  spi_upcount_tx_sched #(.TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset(reset), .i_tick(b_tick), .i_force(b_force),
    .i_counter(counter), .i_runstop(runstop), .i_err_clr(err_clr),
    .o_start(b_start), .o_tx_data(b_tx), .i_done(b_done), .o_ss(b_ss),
    .o_busy(b_busy), .o_overrun(b_ovr), .o_timeout(b_to), .o_frame_cnt(b_fc)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0;
  int ss_bad = 0, tx_unstable = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-16s = 0x%0h", tag, got);
    end else begin
      $display("FAIL %-16s got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] a_bytes[$], b_bytes[$];
  int         a_sc[$], a_dc[$];
  logic [7:0] a_held, b_held;
  bit         b_en = 1'b0;

  // Start monitor and SS/busy consistency: SS must be low exactly while busy.
  initial forever begin
    @(negedge clk);
    if (a_start) begin a_bytes.push_back(a_tx); a_sc.push_back(cyc); end
    if (b_start) b_bytes.push_back(b_tx);
    if (a_ss == a_busy) ss_bad++;
    if (b_ss == b_busy) ss_bad++;
  end

  // SPI master model for dut_a: done 20 cycles after each start.
  initial forever begin
    @(negedge clk);
    if (a_start) begin
      a_held = a_tx;
      repeat (20) @(negedge clk);
      if (a_tx !== a_held) tx_unstable++;
      a_done = 1'b1;
      a_dc.push_back(cyc);
      @(negedge clk);
      a_done = 1'b0;
    end
  end

  // SPI master model for dut_b: done 3 cycles after start, only when enabled.
  initial forever begin
    @(negedge clk);
    if (b_en && b_start) begin
      b_held = b_tx;
      repeat (3) @(negedge clk);
      if (b_tx !== b_held) tx_unstable++;
      b_done = 1'b1;
      @(negedge clk);
      b_done = 1'b0;
    end
  end

  function automatic logic [7:0] a_byte(input int i);
    return (i < a_bytes.size()) ? a_bytes[i] : 8'hEE;
  endfunction
  function automatic logic [7:0] b_byte(input int i);
    return (i < b_bytes.size()) ? b_bytes[i] : 8'hEE;
  endfunction
  function automatic int a_start_at(input int i);
    return (i < a_sc.size()) ? a_sc[i] : -1000;
  endfunction
  function automatic int a_done_at(input int i);
    return (i < a_dc.size()) ? a_dc[i] : -1000;
  endfunction

  task automatic pulse_a_tick(output int t);
    @(negedge clk); a_tick = 1'b1; t = cyc;
    @(negedge clk); a_tick = 1'b0;
  endtask
  task automatic pulse_a_tick_at(input int c);
    while (cyc < c) @(negedge clk);
    a_tick = 1'b1;
    @(negedge clk); a_tick = 1'b0;
  endtask
  task automatic pulse_a_force(output int t);
    @(negedge clk); a_force = 1'b1; t = cyc;
    @(negedge clk); a_force = 1'b0;
  endtask
  task automatic pulse_b_tick(output int t);
    @(negedge clk); b_tick = 1'b1; t = cyc;
    @(negedge clk); b_tick = 1'b0;
  endtask
  task automatic pulse_err_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  // Bounded wait for idle; returns the idle cycle and how many busy cycles were seen.
  task automatic wait_idle_a(output int c, output int nbusy);
    nbusy = 0;
    while (a_busy && nbusy < 400) begin @(negedge clk); nbusy++; end
    c = cyc;
    check_val("a_idle_reached", 32'(a_busy), 32'd0);
  endtask
  task automatic wait_idle_b(output int c);
    int k = 0;
    while (b_busy && k < 400) begin @(negedge clk); k++; end
    c = cyc;
    check_val("b_idle_reached", 32'(b_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    int t, c, nb, k;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_ss", 32'(a_ss), 32'd1);
    check_val("rst_start", 32'(a_start), 32'd0);
    check_val("rst_tx", 32'(a_tx), 32'd0);
    check_val("rst_busy", 32'(a_busy), 32'd0);
    check_val("rst_overrun", 32'(a_ovr), 32'd0);
    check_val("rst_timeout", 32'(a_to), 32'd0);
    check_val("rst_frame_cnt", 32'(a_fc), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic frame, run=1, counter 0x1ABC
    counter = 14'h1ABC; runstop = 1'b1;
    a_bytes.delete(); a_sc.delete(); a_dc.delete();
    pulse_a_tick(t);
    wait_idle_a(c, nb);
    check_val("t1_nbytes", 32'(a_bytes.size()), 32'd2);
    check_val("t1_byte0", 32'(a_byte(0)), 32'h9A);
    check_val("t1_byte1", 32'(a_byte(1)), 32'hBC);
    check_val("t1_start_lat", 32'(a_start_at(0) - t), 32'd3);
    check_val("t1_gap", 32'(a_start_at(1) - a_done_at(0)), 32'd4);
    check_val("t1_idle_at", 32'(c - t), 32'd50);
    check_val("t1_frame_cnt", 32'(a_fc), 32'd1);

    // 2: forced frame, run=0, counter 0
    counter = 14'h0000; runstop = 1'b0;
    a_bytes.delete(); a_sc.delete(); a_dc.delete();
    pulse_a_force(t);
    wait_idle_a(c, nb);
    check_val("t2_byte0", 32'(a_byte(0)), 32'h00);
    check_val("t2_byte1", 32'(a_byte(1)), 32'h00);
    check_val("t2_busy_cycles", 32'(nb), 32'd49);
    check_val("t2_idle_at", 32'(c - t), 32'd50);
    check_val("t2_frame_cnt", 32'(a_fc), 32'd2);

    // 3: pending request in WAIT0, overrun in GAP, pending frame re-snapshots
    counter = 14'h0123; runstop = 1'b1;
    a_bytes.delete(); a_sc.delete(); a_dc.delete();
    pulse_a_tick(t);
    pulse_a_tick_at(t + 10);
    check_val("t3_no_ovr_yet", 32'(a_ovr), 32'd0);
    pulse_a_tick_at(t + 25);
    check_val("t3_overrun", 32'(a_ovr), 32'd1);
    counter = 14'h2345;
    wait_idle_a(c, nb);
    check_val("t3_idle_at", 32'(c - t), 32'd50);
    check_val("t3_idle_ss", 32'(a_ss), 32'd1);
    @(negedge clk);
    check_val("t3_rebusy", 32'(a_busy), 32'd1);
    wait_idle_a(c, nb);
    check_val("t3_byte0", 32'(a_byte(0)), 32'h81);
    check_val("t3_byte1", 32'(a_byte(1)), 32'h23);
    check_val("t3_byte2", 32'(a_byte(2)), 32'hA3);
    check_val("t3_byte3", 32'(a_byte(3)), 32'h45);
    check_val("t3_start2_lat", 32'(a_start_at(2) - t), 32'd53);
    check_val("t3_frame_cnt", 32'(a_fc), 32'd4);
    pulse_err_clr();
    check_val("t3_ovr_cleared", 32'(a_ovr), 32'd0);

    // 4: no done -> timeout after 16 WAIT0 cycles (dut_b)
    counter = 14'h0555; runstop = 1'b1;
    b_en = 1'b0;
    pulse_b_tick(t);
    k = 0;
    while (!b_to && k < 100) begin @(negedge clk); k++; end
    check_val("t4_timeout", 32'(b_to), 32'd1);
    check_val("t4_to_at", 32'(cyc - t), 32'd19);
    check_val("t4_ss", 32'(b_ss), 32'd1);
    check_val("t4_busy", 32'(b_busy), 32'd0);
    @(negedge clk); b_done = 1'b1;
    @(negedge clk); b_done = 1'b0;
    @(negedge clk);
    check_val("t4_late_done_cnt", 32'(b_fc), 32'd0);
    check_val("t4_late_done_bsy", 32'(b_busy), 32'd0);
    b_en = 1'b1;
    b_bytes.delete();
    pulse_b_tick(t);
    wait_idle_b(c);
    check_val("t4_byte0", 32'(b_byte(0)), 32'h85);
    check_val("t4_byte1", 32'(b_byte(1)), 32'h55);
    check_val("t4_frame_cnt", 32'(b_fc), 32'd1);
    check_val("t4_to_sticky", 32'(b_to), 32'd1);
    pulse_err_clr();
    check_val("t4_to_cleared", 32'(b_to), 32'd0);

    // 5: asynchronous reset while in GAP
    counter = 14'h3FFF; runstop = 1'b0;
    pulse_a_tick(t);
    while (cyc < t + 25) @(negedge clk);
    check_val("t5_busy_before", 32'(a_busy), 32'd1);
    reset = 1'b1;
    #1;
    check_val("t5_rst_ss", 32'(a_ss), 32'd1);
    check_val("t5_rst_start", 32'(a_start), 32'd0);
    check_val("t5_rst_busy", 32'(a_busy), 32'd0);
    check_val("t5_rst_frame_cnt", 32'(a_fc), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    a_bytes.delete(); a_sc.delete(); a_dc.delete();
    pulse_a_tick(t);
    wait_idle_a(c, nb);
    check_val("t5_byte0", 32'(a_byte(0)), 32'h3F);
    check_val("t5_byte1", 32'(a_byte(1)), 32'hFF);
    check_val("t5_start_lat", 32'(a_start_at(0) - t), 32'd3);
    check_val("t5_frame_cnt", 32'(a_fc), 32'd1);

    // 6: frame counter wrap 0xFFFF -> 0 (dut_b preloaded)
    force dut_b.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut_b.r_frame_cnt;
    @(negedge clk);
    check_val("t6_preload", 32'(b_fc), 32'hFFFF);
    pulse_b_tick(t);
    wait_idle_b(c);
    check_val("t6_wrap", 32'(b_fc), 32'd0);

    check_val("ss_vs_busy", 32'(ss_bad), 32'd0);
    check_val("tx_stable", 32'(tx_unstable), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
